// File: rtl/wb_xbar_pkg.sv
// Shared types, defaults and width helpers for the 1-to-N Wishbone crossbar.
package wb_xbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } xbar_state_e;

  localparam int          DEF_SEL_LSB  = 16;
  localparam int          DEF_SEL_W    = 4;
  localparam int          DEF_TIMEOUT  = 255;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  // SEL_HI: first address bit above the slave-select field.
  function automatic int sel_hi(input int sel_lsb, input int sel_w);
    return sel_lsb + sel_w;
  endfunction

  // TMR_W: timer width able to hold every value up to the timeout.
  function automatic int tmr_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_xbar_decode.sv
// Combinational slave-select decoder: extracts the slave index and checks the base window.
module wb_xbar_decode
  import wb_xbar_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter int          SEL_LSB    = DEF_SEL_LSB,
  parameter int          SEL_W      = DEF_SEL_W,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic [31:SEL_LSB] adr_hi_i,
  output logic [SEL_W-1:0]  idx_o,
  output logic              mapped_o
);

  localparam int SEL_HI = sel_hi(SEL_LSB, SEL_W);

  assign idx_o    = adr_hi_i[SEL_LSB +: SEL_W];
  assign mapped_o = (adr_hi_i[31:SEL_HI] == BASE_ADDR[31:SEL_HI]) &&
                    (32'(idx_o) < 32'(NUM_SLAVES));

endmodule

// File: rtl/wb_xbar_1xn.sv
// Single-master, N-slave Wishbone classic interconnect with decode-error,
// timeout and abort handling plus error statistics.
module wb_xbar_1xn
  import wb_xbar_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter int          DW         = 32,
  parameter int          SLV_AW     = 9,
  parameter int          SEL_LSB    = DEF_SEL_LSB,
  parameter int          SEL_W      = DEF_SEL_W,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          TIMEOUT    = DEF_TIMEOUT,
  parameter logic [DW-1:0] ERR_DATA = DW'(DEF_ERR_DATA)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     m_wb_cyc_i,
  input  logic                     m_wb_stb_i,
  input  logic                     m_wb_we_i,
  input  logic [31:0]              m_wb_adr_i,
  input  logic [DW-1:0]            m_wb_dat_i,
  input  logic [DW/8-1:0]          m_wb_sel_i,
  output logic [DW-1:0]            m_wb_dat_o,
  output logic                     m_wb_ack_o,
  output logic                     m_wb_err_o,
  output logic [NUM_SLAVES-1:0]    s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_wb_stb_o,
  output logic                     s_wb_we_o,
  output logic [SLV_AW-1:0]        s_wb_adr_o,
  output logic [DW-1:0]            s_wb_dat_o,
  output logic [DW/8-1:0]          s_wb_sel_o,
  input  logic [NUM_SLAVES*DW-1:0] s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_wb_ack_i,
  output logic [7:0]               err_cnt_o,
  output logic [31:0]              last_err_adr_o,
  output logic                     last_err_to_o,
  output logic [1:0]               dbg_state_o
);

  // Handshake: a request is valid while cyc & stb are high and is held until
  // ack is sampled; ack completes it, and err qualifies ack as a failure.

  localparam int TW = tmr_w(TIMEOUT);

  xbar_state_e           state_q, state_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [31:0]           adr_q, adr_d;
  logic [DW-1:0]         dat_q, dat_d;
  logic [DW/8-1:0]       sel_q, sel_d;
  logic                  we_q, we_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [DW-1:0]         rdat_q, rdat_d;
  logic                  to_q, to_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DW-1:0]         mdat_q, mdat_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [31:0]           lea_q, lea_d;
  logic                  leto_q, leto_d;

  logic [SEL_W-1:0]      dec_idx;
  logic                  dec_mapped;
  logic [NUM_SLAVES-1:0] onehot;
  logic                  sel_ack;
  logic [DW-1:0]         sel_rdat;

  wb_xbar_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_LSB    (SEL_LSB),
    .SEL_W      (SEL_W),
    .BASE_ADDR  (BASE_ADDR)
  ) u_decode (
    .adr_hi_i (m_wb_adr_i[31:SEL_LSB]),
    .idx_o    (dec_idx),
    .mapped_o (dec_mapped)
  );

  always_comb begin
    onehot   = '0;
    sel_rdat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      onehot[k] = (idx_q == SEL_W'(k));
      if (onehot[k]) sel_rdat = s_wb_dat_i[k*DW +: DW];
    end
    sel_ack = |(s_wb_ack_i & onehot);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    tmr_d     = tmr_q;
    rdat_d    = rdat_q;
    to_d      = to_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    mdat_d    = '0;
    err_cnt_d = err_cnt_q;
    lea_d     = lea_q;
    leto_d    = leto_q;
    case (state_q)
      ST_IDLE: begin
        // While the previous ack is still on the bus the master's stb is stale.
        if (m_wb_cyc_i && m_wb_stb_i && !ack_q) begin
          idx_d = dec_idx;
          adr_d = m_wb_adr_i;
          dat_d = m_wb_dat_i;
          sel_d = m_wb_sel_i;
          we_d  = m_wb_we_i;
          tmr_d = '0;
          to_d  = 1'b0;
          state_d = dec_mapped ? ST_REQ : ST_ERR;
        end
      end
      ST_REQ: begin
        if (!m_wb_cyc_i) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          rdat_d  = sel_rdat;
          tmr_d   = '0;
          state_d = ST_RESP;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          tmr_d   = '0;
          state_d = ST_ERR;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_RESP: begin
        ack_d   = 1'b1;
        mdat_d  = we_q ? '0 : rdat_q;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        ack_d  = 1'b1;
        err_d  = 1'b1;
        mdat_d = ERR_DATA;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        lea_d   = adr_q;
        leto_d  = to_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      tmr_q     <= '0;
      rdat_q    <= '0;
      to_q      <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      mdat_q    <= '0;
      err_cnt_q <= '0;
      lea_q     <= '0;
      leto_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      tmr_q     <= tmr_d;
      rdat_q    <= rdat_d;
      to_q      <= to_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      mdat_q    <= mdat_d;
      err_cnt_q <= err_cnt_d;
      lea_q     <= lea_d;
      leto_q    <= leto_d;
    end
  end

  assign s_wb_cyc_o     = (state_q == ST_REQ) ? onehot : '0;
  assign s_wb_stb_o     = (state_q == ST_REQ) ? onehot : '0;
  assign s_wb_we_o      = we_q;
  assign s_wb_adr_o     = adr_q[SLV_AW-1:0];
  assign s_wb_dat_o     = dat_q;
  assign s_wb_sel_o     = sel_q;
  assign m_wb_ack_o     = ack_q;
  assign m_wb_err_o     = err_q;
  assign m_wb_dat_o     = mdat_q;
  assign err_cnt_o      = err_cnt_q;
  assign last_err_adr_o = lea_q;
  assign last_err_to_o  = leto_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_wb_xbar_1xn.sv
// Directed self-checking bench for wb_xbar_1xn (4 slaves, TIMEOUT = 8).
module tb_wb_xbar_1xn;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [31:0]  adr, wdat;
  logic [3:0]   sel;
  logic [31:0]  m_dat;
  logic         m_ack, m_err;
  logic [3:0]   s_cyc, s_stb;
  logic         s_we;
  logic [8:0]   s_adr;
  logic [31:0]  s_wdat;
  logic [3:0]   s_sel;
  logic [127:0] s_dat;
  logic [3:0]   s_ack;
  logic [7:0]   err_cnt;
  logic [31:0]  last_adr;
  logic         last_to;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  // Per-transfer observations filled by xfer().
  int          ack_at;
  int          stb_cnt;
  logic [3:0]  seen;
  logic [31:0] r_dat;
  logic        r_err;
  logic [8:0]  f_adr;
  logic [31:0] f_dat;
  logic        f_we;
  logic [3:0]  f_sel;

  always #5 clk = ~clk;

  wb_xbar_1xn #(.NUM_SLAVES(4), .TIMEOUT(8)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .m_wb_cyc_i     (cyc),
    .m_wb_stb_i     (stb),
    .m_wb_we_i      (we),
    .m_wb_adr_i     (adr),
    .m_wb_dat_i     (wdat),
    .m_wb_sel_i     (sel),
    .m_wb_dat_o     (m_dat),
    .m_wb_ack_o     (m_ack),
    .m_wb_err_o     (m_err),
    .s_wb_cyc_o     (s_cyc),
    .s_wb_stb_o     (s_stb),
    .s_wb_we_o      (s_we),
    .s_wb_adr_o     (s_adr),
    .s_wb_dat_o     (s_wdat),
    .s_wb_sel_o     (s_sel),
    .s_wb_dat_i     (s_dat),
    .s_wb_ack_i     (s_ack),
    .err_cnt_o      (err_cnt),
    .last_err_adr_o (last_adr),
    .last_err_to_o  (last_to),
    .dbg_state_o    (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drives one master request and plays slave `slv` (-1 = none), which acks
  // on its (wait_n+1)-th strobed cycle. Inputs change on negedges only.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] be, input int slv, input int wait_n,
                      input logic [31:0] rd);
    int  n;
    bit  done;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = be;
    n = 0; done = 0; ack_at = -1; stb_cnt = 0; seen = '0;
    r_dat = '0; r_err = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      s_ack = '0;
      if (m_ack) begin
        ack_at = n; r_dat = m_dat; r_err = m_err; done = 1;
      end else if (s_stb != '0) begin
        seen = seen | s_stb;
        stb_cnt++;
        if (stb_cnt == 1) begin
          f_adr = s_adr; f_dat = s_wdat; f_we = s_we; f_sel = s_sel;
        end
        if (slv >= 0 && s_stb[slv] && stb_cnt == wait_n + 1) begin
          s_ack[slv] = 1'b1;
          s_dat[slv*32 +: 32] = rd;
        end
      end
    end
    if (!done) chk("ack_wait_bound", 32'(ack_at), 32'hFFFF_FFFF - 32'd1);
    // Master keeps stb across the edge where it samples ack, then drops it.
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    chk("ack_one_cycle", 32'(m_ack), 32'd0);
    chk("no_reaccept", 32'(s_cyc), 32'd0);
    chk("dat_idle_zero", m_dat, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0; s_dat = '0; s_ack = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(m_ack), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_dat", m_dat, 32'd0);
    chk("rst_cyc", 32'(s_cyc), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    chk("rst_last_adr", last_adr, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write to slave 0, ack on the first strobed cycle.
    xfer(32'h3000_0004, 1'b1, 32'h1234_5678, 4'hF, 0, 0, 32'h0);
    chk("wr_seen", 32'(seen), 32'h1);
    chk("wr_adr", 32'(f_adr), 32'h004);
    chk("wr_dat", f_dat, 32'h1234_5678);
    chk("wr_we", 32'(f_we), 32'd1);
    chk("wr_sel", 32'(f_sel), 32'hF);
    chk("wr_ack_at", 32'(ack_at), 32'd3);
    chk("wr_err", 32'(r_err), 32'd0);
    chk("wr_mdat", r_dat, 32'd0);

    // Read from slave 2 with 3 wait cycles.
    xfer(32'h3002_0010, 1'b0, 32'h0, 4'hF, 2, 3, 32'hCAFE_F00D);
    chk("rd_seen", 32'(seen), 32'h4);
    chk("rd_adr", 32'(f_adr), 32'h010);
    chk("rd_ack_at", 32'(ack_at), 32'd6);
    chk("rd_dat", r_dat, 32'hCAFE_F00D);
    chk("rd_err", 32'(r_err), 32'd0);

    // Decode errors: index out of range, then base mismatch.
    xfer(32'h3005_0000, 1'b0, 32'h0, 4'hF, -1, 0, 32'h0);
    chk("dec1_seen", 32'(seen), 32'h0);
    chk("dec1_ack_at", 32'(ack_at), 32'd2);
    chk("dec1_err", 32'(r_err), 32'd1);
    chk("dec1_dat", r_dat, 32'hDEAD_BEEF);
    xfer(32'h4000_0000, 1'b0, 32'h0, 4'hF, -1, 0, 32'h0);
    chk("dec2_ack_at", 32'(ack_at), 32'd2);
    chk("dec2_err", 32'(r_err), 32'd1);
    chk("dec2_dat", r_dat, 32'hDEAD_BEEF);
    chk("dec_cnt", 32'(err_cnt), 32'd2);
    chk("dec_to", 32'(last_to), 32'd0);
    chk("dec_last_adr", last_adr, 32'h4000_0000);

    // Slave 1 never acks: 8 strobed cycles then timeout error.
    xfer(32'h3001_0020, 1'b0, 32'h0, 4'hF, -1, 0, 32'h0);
    chk("to_stb_cnt", 32'(stb_cnt), 32'd8);
    chk("to_seen", 32'(seen), 32'h2);
    chk("to_ack_at", 32'(ack_at), 32'd10);
    chk("to_err", 32'(r_err), 32'd1);
    chk("to_dat", r_dat, 32'hDEAD_BEEF);
    chk("to_flag", 32'(last_to), 32'd1);
    chk("to_last_adr", last_adr, 32'h3001_0020);
    chk("to_cnt", 32'(err_cnt), 32'd3);

    // Ack on the 8th strobed cycle beats the timeout.
    xfer(32'h3001_0024, 1'b0, 32'h0, 4'hF, 1, 7, 32'h0BAD_CAFE);
    chk("late_stb_cnt", 32'(stb_cnt), 32'd8);
    chk("late_err", 32'(r_err), 32'd0);
    chk("late_dat", r_dat, 32'h0BAD_CAFE);
    chk("late_cnt", 32'(err_cnt), 32'd3);

    // Master abort during REQ.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3001_0000;
    repeat (3) @(negedge clk);
    chk("abort_stb_before", 32'(s_stb), 32'h2);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("abort_stb", 32'(s_stb), 32'h0);
    chk("abort_ack", 32'(m_ack), 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_ack_later", 32'(m_ack), 32'd0);
    chk("abort_cnt", 32'(err_cnt), 32'd3);

    // Reset pulsed mid-REQ clears strobes immediately.
    cyc = 1'b1; stb = 1'b1; adr = 32'h3001_0000;
    repeat (2) @(negedge clk);
    chk("rstreq_stb_before", 32'(s_stb), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("rstreq_stb", 32'(s_stb), 32'h0);
    chk("rstreq_cnt", 32'(err_cnt), 32'd0);
    chk("rstreq_ack", 32'(m_ack), 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);

    // 300 decode errors saturate the counter.
    for (int i = 0; i < 300; i++) begin
      xfer(32'h300F_0000, 1'b0, 32'h0, 4'hF, -1, 0, 32'h0);
      if (i == 254) chk("sat_cnt_255", 32'(err_cnt), 32'd255);
    end
    chk("sat_cnt", 32'(err_cnt), 32'd255);
    chk("sat_last_adr", last_adr, 32'h300F_0000);
    chk("sat_to", 32'(last_to), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/wb_xbar_1xn.md
Name: wb_xbar_1xn

Overview:
- Parametrised single-master, N-slave Wishbone classic interconnect; successor to the fixed 4-slave interconnect in the user project.
- Decodes a slave-select field from the master address and forwards the cycle to one slave through registered request and response paths.
- Adds behaviour the fixed version lacks: a decode-error response for unmapped addresses, a per-transaction timeout, abort handling and error statistics.
- Sits between the Caravel management Wishbone port and the SRAM, UART, TRNG and SPI wrappers.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- DW, 32, data width (multiple of 8).
- SLV_AW, 9, low address bits forwarded to slaves.
- SEL_LSB, 16, bit position of the slave-select field in the master address.
- SEL_W, 4, width of the slave-select field.
- BASE_ADDR, 32'h3000_0000, required value of master address bits [31:SEL_LSB+SEL_W].
- TIMEOUT, 255, maximum cycles to wait for slave ack (1..65535).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on any error.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- m_wb_cyc_i, m_wb_stb_i, m_wb_we_i  in  1 each  master control.
- m_wb_adr_i  in  32  master address.
- m_wb_dat_i  in  DW  master write data.
- m_wb_sel_i  in  DW/8  byte enables.
- m_wb_dat_o  out  DW  read data to master.
- m_wb_ack_o  out  1  transfer complete, success or error.
- m_wb_err_o  out  1  error qualifier, valid only with ack.
- s_wb_cyc_o, s_wb_stb_o  out  NUM_SLAVES  one-hot per-slave control.
- s_wb_we_o  out  1  shared write enable.
- s_wb_adr_o  out  SLV_AW  shared address.
- s_wb_dat_o  out  DW  shared write data.
- s_wb_sel_o  out  DW/8  shared byte enables.
- s_wb_dat_i  in  NUM_SLAVES*DW  slave read data, slave k in bits [k*DW +: DW].
- s_wb_ack_i  in  NUM_SLAVES  slave acks.
- err_cnt_o  out  8  saturating error count.
- last_err_adr_o  out  32  address of the most recent error.
- last_err_to_o  out  1  1 = last error was a timeout, 0 = decode error.

Behaviour:
- Reset (async assert, sync deassert):
  - all outputs 0, state IDLE, timer 0.
  - All registers are reset, so err_cnt_o and last_err_adr_o reset to 0.
- Index idx = m_wb_adr_i[SEL_LSB +: SEL_W].
- Mapped means m_wb_adr_i[31:SEL_LSB+SEL_W] == BASE_ADDR[31:SEL_LSB+SEL_W] and idx < NUM_SLAVES.
- FSM states: IDLE, REQ, RESP, ERR.
- IDLE:
  - On m_wb_cyc_i & m_wb_stb_i, latch idx, adr[SLV_AW-1:0], dat, sel and we.
  - If mapped, go to REQ. Otherwise go to ERR with decode-error flag.
- REQ:
  - s_wb_cyc_o[idx] and s_wb_stb_o[idx] are high, all other bits 0. Shared outputs hold the latched values.
  - Timer increments each cycle.
  - On s_wb_ack_i[idx]: capture s_wb_dat_i slice, drop strobes next cycle, go to RESP.
  - Acks from non-selected slaves are ignored.
  - If timer == TIMEOUT-1 with no ack: drop strobes, go to ERR with timeout flag.
  - Ack and timeout in the same cycle: ack wins.
  - If m_wb_cyc_i falls (abort): drop strobes, clear timer, go to IDLE. No master ack, no error logged.
- RESP: m_wb_ack_o=1 and m_wb_err_o=0 for exactly one cycle. m_wb_dat_o = captured data on reads, 0 on writes. Go to IDLE.
- ERR:
  - m_wb_ack_o=1 and m_wb_err_o=1 for one cycle; m_wb_dat_o=ERR_DATA.
  - err_cnt_o increments, saturating at 255.
  - last_err_adr_o and last_err_to_o update.
  - Go to IDLE.
- Latency:
  - Request sampled at edge 0; slave stb visible after edge 0.
  - Slave ack sampled at edge k gives master ack after edge k+1.
  - Decode error gives master ack after edge 1.
- m_wb_dat_o returns to 0 outside ack cycles.
- A new request is never accepted in RESP or ERR. Back-to-back transfers have one idle cycle minimum.

Decomposition:
- Package wb_xbar_pkg holds:
  - FSM state enum.
  - Derived localparams: SEL_HI = SEL_LSB+SEL_W, TMR_W = $clog2(TIMEOUT+1).
  - ERR_DATA default.
- Sub-module wb_xbar_decode: combinational address decoder producing idx and mapped. It is instantiated once and reused for future multi-master versions.

Test Plan:
- Write 0x1234_5678, sel 4'hF, to 0x3000_0004 (idx 0), slave 0 acks 1 cycle after stb -> s_wb_cyc_o=4'b0001, s_wb_adr_o=9'h004, m_wb_ack_o 1 cycle later, err=0.
- Read 0x3002_0010 (idx 2), slave 2 returns 0xCAFE_F00D after 3 wait cycles -> m_wb_dat_o=0xCAFE_F00D, ack 1 cycle after slave ack; slaves 0, 1, 3 never strobed.
- Read 0x3005_0000 (idx 5 >= 4) and 0x4000_0000 (base mismatch) -> both ack+err at cycle 1, data 0xDEAD_BEEF, err_cnt_o=2, last_err_to_o=0, last_err_adr_o=0x4000_0000.
- Slave 1 never acks, TIMEOUT=8 -> strobe high exactly 8 cycles, then ack+err, last_err_to_o=1; slave ack arriving on the 8th cycle instead -> normal ack, err=0.
- Master drops cyc during REQ, and separately wb_rst_i pulsed mid-REQ -> strobes low next cycle (immediately for reset), no master ack, err_cnt_o unchanged (0 after reset).
- 300 consecutive decode errors -> err_cnt_o saturates at 255.
